// File: rtl/mod_reduce_arbiter.sv
// Round-robin scheduler sharing one modular_reduction datapath among NREQ requesters.
// Sequences the reducer start/done handshake, aborts hung operations, returns results with backpressure.
module mod_reduce_arbiter #(
    parameter int NREQ    = 4,
    parameter int ID_W    = $clog2(NREQ),
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*48-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [22:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic                 red_start,
    output logic [47:0]          red_data_in,
    input  logic                 red_done,
    input  logic [22:0]          red_data_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [ID_W:0] L_NREQ = (ID_W + 1)'(NREQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_gnt;
    logic [ID_W-1:0]  r_id;
    logic [CNT_W-1:0] r_cnt;
    logic [47:0]      r_op;
    logic [22:0]      r_data;
    logic             r_err;

    logic [47:0]       w_slot [NREQ];
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic [ID_W-1:0]   w_pos;
    logic              w_any;
    logic [ID_W-1:0]   w_gnt;
    logic [ID_W-1:0]   w_ptr_next;
    logic              w_accept;
    logic              w_rsp_hs;

    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W:0] v);
        f_wrap = (v >= L_NREQ) ? ID_W'(v - L_NREQ) : v[ID_W-1:0];
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slot
            assign w_slot[gi] = req_data[48*gi +: 48];
        end
    endgenerate

    // Rotate the request vector so bit 0 is the requester at rr_ptr; lowest set bit wins.
    assign w_dbl = {req_valid, req_valid};
    assign w_rot = w_dbl[r_ptr +: NREQ];

    always_comb begin
        w_pos = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_pos = ID_W'(k);
            end
        end
    end

    assign w_any      = |req_valid;
    assign w_gnt      = f_wrap({1'b0, r_ptr} + {1'b0, w_pos});
    assign w_ptr_next = f_wrap({1'b0, r_gnt} + (ID_W + 1)'(1));
    assign w_accept   = (r_state == S_IDLE) && w_any;
    assign w_rsp_hs   = (r_state == S_RESP) && rsp_ready[r_gnt];

    assign req_ready   = w_accept ? (NREQ'(1) << w_gnt) : '0;
    assign rsp_valid   = (r_state == S_RESP) ? (NREQ'(1) << r_gnt) : '0;
    assign rsp_data    = r_data;
    assign rsp_id      = r_id;
    assign rsp_err     = r_err;
    assign red_start   = (r_state == S_ISSUE);
    assign red_data_in = r_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_id    <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_gnt   <= w_gnt;
                        r_op    <= w_slot[w_gnt];
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // red_done is only honoured here, so a late pulse after an abort is dropped.
                    if (red_done) begin
                        r_data  <= red_data_out;
                        r_err   <= 1'b0;
                        r_id    <= r_gnt;
                        r_state <= S_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        r_data  <= '0;
                        r_err   <= 1'b1;
                        r_id    <= r_gnt;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    if (w_rsp_hs) begin
                        r_ptr   <= w_ptr_next;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_arbiter.sv
// Directed bench for mod_reduce_arbiter: a behavioural reducer with programmable latency
// plus hand-computed expected grants and results.
module tb_mod_reduce_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int TMO  = 8;
    localparam logic [47:0] Q = 48'd8380417;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*48-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [22:0]       rsp_data;
    logic [ID_W-1:0]   rsp_id;
    logic              rsp_err;
    logic              red_start;
    logic [47:0]       red_data_in;
    logic              red_done;
    logic [22:0]       red_data_out;

    mod_reduce_arbiter #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .rsp_err(rsp_err),
        .red_start(red_start), .red_data_in(red_data_in),
        .red_done(red_done), .red_data_out(red_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reducer model: done pulse m_lat cycles after the start pulse, unless m_never is set.
    int          m_lat = 3;
    bit          m_never = 1'b0;
    logic        m_busy;
    int          m_cnt;
    logic [47:0] m_op;
    logic        m_done;
    logic [22:0] m_res;
    logic        kick;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_cnt  <= 0;
            m_op   <= '0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (red_start) begin
                m_busy <= 1'b1;
                m_cnt  <= 1;
                m_op   <= red_data_in;
            end else if (m_busy && !m_never) begin
                if (m_cnt == m_lat - 1) begin
                    m_done <= 1'b1;
                    m_res  <= 23'(m_op % Q);
                    m_busy <= 1'b0;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    assign red_done     = m_done | kick;
    assign red_data_out = kick ? 23'h7FFFFF : m_res;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_slot(input int id, input logic [47:0] v);
        req_data[48*id +: 48] = v;
    endtask

    // Called at negedge+1; waits for a grant, checks it, then checks the issue cycle.
    task automatic grant(input int id, input logic [47:0] op, input bit keep);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        chk("grant_seen", 64'(ok), 64'd1);
        chk("grant_onehot", 64'(req_ready), 64'd1 << id);
        @(negedge clk);
        if (!keep) req_valid[id] = 1'b0;
        #1;
        chk("red_start", 64'(red_start), 64'd1);
        chk("red_data_in", 64'(red_data_in), 64'(op));
        chk("ready_in_issue", 64'(req_ready), 64'd0);
    endtask

    task automatic wait_rsp();
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        chk("rsp_seen", 64'(ok), 64'd1);
    endtask

    task automatic take(input int id, input logic [22:0] d, input bit e);
        wait_rsp();
        chk("rsp_valid", 64'(rsp_valid), 64'd1 << id);
        chk("rsp_data", 64'(rsp_data), 64'(d));
        chk("rsp_id", 64'(rsp_id), 64'(id));
        chk("rsp_err", 64'(rsp_err), 64'(e));
        $display("rsp id=%0d data=%0d err=%0b", rsp_id, rsp_data, rsp_err);
        rsp_ready = '1;
        @(negedge clk);
        rsp_ready = '0;
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        kick      = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_red_start"}, 64'(red_start), 64'd0);
        chk({tag, "_red_data_in"}, 64'(red_data_in), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = '0;
        kick      = 1'b0;
        #1;
        chk_all_zero("reset");
        do_reset();
        chk_all_zero("post_reset");

        // Single request, L=3: accept cycle 0, start cycle 1, rsp_valid cycle 5.
        set_slot(0, 48'd1000000);
        req_valid = 4'b0001;
        #1;
        chk("c0_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("c1_red_start", 64'(red_start), 64'd1);
        chk("c1_red_data_in", 64'(red_data_in), 64'd1000000);
        repeat (3) @(negedge clk);
        #1;
        chk("c4_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        chk("c5_rsp_valid", 64'(rsp_valid), 64'd1);
        take(0, 23'd1000000, 1'b0);

        // All four valid from reset: grants 0,1,2,3.
        do_reset();
        set_slot(0, 48'd8380417);
        set_slot(1, 48'd16760834);
        set_slot(2, 48'd1000000);
        set_slot(3, 48'd5);
        req_valid = 4'b1111;
        #1;
        grant(0, 48'd8380417, 1'b0);  take(0, 23'd0, 1'b0);
        grant(1, 48'd16760834, 1'b0); take(1, 23'd0, 1'b0);
        grant(2, 48'd1000000, 1'b0);  take(2, 23'd1000000, 1'b0);
        grant(3, 48'd5, 1'b0);        take(3, 23'd5, 1'b0);

        // Fairness: pointer back at 0, requester 0 keeps asserting while 3 waits.
        set_slot(0, 48'd100);
        set_slot(3, 48'd200);
        req_valid = 4'b1001;
        #1;
        grant(0, 48'd100, 1'b1); take(0, 23'd100, 1'b0);
        grant(3, 48'd200, 1'b0); take(3, 23'd200, 1'b0);
        req_valid = '0;
        #1;

        // Backpressure on requester 2 for 10 cycles, with a competing request pending.
        set_slot(2, 48'd8380418);
        req_valid = 4'b0100;
        #1;
        grant(2, 48'd8380418, 1'b0);
        wait_rsp();
        set_slot(0, 48'd20000000);
        req_valid = 4'b0001;
        rsp_ready = 4'b1011;
        #1;
        for (int i = 0; i < 10; i++) begin
            chk("hold_rsp_valid", 64'(rsp_valid), 64'd4);
            chk("hold_rsp_data", 64'(rsp_data), 64'd1);
            chk("hold_rsp_id", 64'(rsp_id), 64'd2);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk); #1;
        end
        rsp_ready = '0;
        take(2, 23'd1, 1'b0);
        grant(0, 48'd20000000, 1'b0); take(0, 23'd3239166, 1'b0);

        // Timeout: no done; rsp_valid 10 cycles after red_start, late done ignored.
        m_never = 1'b1;
        set_slot(1, 48'd77);
        req_valid = 4'b0010;
        #1;
        grant(1, 48'd77, 1'b0);
        repeat (9) @(negedge clk);
        #1;
        chk("tmo_c10_no_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk); #1;
        chk("tmo_c11_rsp", 64'(rsp_valid), 64'd2);
        take(1, 23'd0, 1'b1);
        @(negedge clk);
        kick = 1'b1;
        @(negedge clk);
        kick = 1'b0;
        #1;
        chk("late_done_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("late_done_rsp_data", 64'(rsp_data), 64'd0);
        m_never = 1'b0;
        set_slot(2, 48'd9000000);
        req_valid = 4'b0100;
        #1;
        grant(2, 48'd9000000, 1'b0); take(2, 23'd619583, 1'b0);

        // Reset during WAIT: outputs clear without a clock edge; pointer restarts at 0.
        set_slot(3, 48'd12345);
        req_valid = 4'b1000;
        #1;
        grant(3, 48'd12345, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_wait_reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_slot(1, 48'd8380416);
        set_slot(3, 48'd42);
        req_valid = 4'b1010;
        #1;
        grant(1, 48'd8380416, 1'b0); take(1, 23'd8380416, 1'b0);
        grant(3, 48'd42, 1'b0);      take(3, 23'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
